// File: rtl/track_ctrl.sv
// Box-tracking controller: manual steering, template capture for one frame,
// then step-limited following of matcher candidates with loss detection.
module track_ctrl #(
  parameter int VGA_WIDTH      = 640,
  parameter int VGA_HEIGHT     = 480,
  parameter int TEMPLATE_WIDTH = 32,
  parameter int MAX_STEP       = 16,
  parameter int LOST_FRAMES    = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        frame_start,
  input  logic        track_req,
  input  logic        cancel,
  input  logic [9:0]  manual_x,
  input  logic [9:0]  manual_y,
  input  logic        cand_valid,
  input  logic [9:0]  cand_x,
  input  logic [9:0]  cand_y,
  input  logic [15:0] cand_score,
  input  logic [15:0] score_thresh,
  output logic        capture_en,
  output logic        tracking_mode,
  output logic        max_ready,
  output logic [9:0]  c_x,
  output logic [9:0]  c_y,
  output logic        lost,
  output logic [1:0]  state
);

  typedef enum logic [1:0] {
    StManual  = 2'd0,
    StArm     = 2'd1,
    StCapture = 2'd2,
    StTrack   = 2'd3
  } state_t;

  localparam int HALF = TEMPLATE_WIDTH / 2;
  localparam int XMIN = HALF;
  localparam int XMAX = VGA_WIDTH - 1 - HALF;
  localparam int YMIN = HALF;
  localparam int YMAX = VGA_HEIGHT - 1 - HALF;
  localparam int MW   = $clog2(LOST_FRAMES + 1);

  localparam logic [MW-1:0] MissLast = MW'(LOST_FRAMES - 1);
  localparam logic [MW-1:0] MissFull = MW'(LOST_FRAMES);
  localparam logic [9:0]    CxReset  = 10'(VGA_WIDTH / 2);
  localparam logic [9:0]    CyReset  = 10'(VGA_HEIGHT / 2);

  state_t        r_state;
  logic [9:0]    r_c_x;
  logic [9:0]    r_c_y;
  logic          r_max_ready;
  logic          r_lost;
  logic          r_hit;
  logic [MW-1:0] r_miss;
  logic          w_accept;

  // Saturate to the legal centre range; computed in int so 1023 cannot wrap.
  function automatic logic [9:0] clamp(input int v, input int lo, input int hi);
    int r;
    r = v;
    if (r < lo) r = lo;
    if (r > hi) r = hi;
    return 10'(r);
  endfunction

  // Move c toward cand by at most MAX_STEP, then keep the result in range.
  function automatic logic [9:0] step(input logic [9:0] c, input logic [9:0] cand,
                                     input int lo, input int hi);
    int d;
    d = int'(cand) - int'(c);
    if (d > MAX_STEP) d = MAX_STEP;
    if (d < -MAX_STEP) d = -MAX_STEP;
    return clamp(int'(c) + d, lo, hi);
  endfunction

  // A candidate only counts in TRACK and at or above the threshold.
  assign w_accept = (r_state == StTrack) && cand_valid && (cand_score >= score_thresh);

  // State, centre, loss bookkeeping and the max_ready pulse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= StManual;
      r_c_x       <= CxReset;
      r_c_y       <= CyReset;
      r_max_ready <= 1'b0;
      r_lost      <= 1'b0;
      r_hit       <= 1'b0;
      r_miss      <= '0;
    end else begin
      r_max_ready <= 1'b0;
      if (cancel && (r_state != StManual)) begin
        r_state <= StManual;
      end else begin
        unique case (r_state)
          StManual: begin
            r_c_x <= clamp(int'(manual_x), XMIN, XMAX);
            r_c_y <= clamp(int'(manual_y), YMIN, YMAX);
            if (track_req) begin
              r_state <= StArm;
              r_lost  <= 1'b0;
            end
          end
          StArm: begin
            if (frame_start) r_state <= StCapture;
          end
          StCapture: begin
            if (frame_start) begin
              r_state <= StTrack;
              r_miss  <= '0;
              r_hit   <= 1'b0;
            end
          end
          StTrack: begin
            if (w_accept) begin
              r_c_x       <= step(r_c_x, cand_x, XMIN, XMAX);
              r_c_y       <= step(r_c_y, cand_y, YMIN, YMAX);
              r_max_ready <= 1'b1;
            end
            if (frame_start) begin
              // A candidate arriving with frame_start belongs to the closing frame.
              r_hit <= 1'b0;
              if (r_hit || w_accept) begin
                r_miss <= '0;
              end else if (r_miss == MissLast) begin
                r_miss  <= MissFull;
                r_state <= StManual;
                r_lost  <= 1'b1;
              end else begin
                r_miss <= r_miss + 1'b1;
              end
            end else if (w_accept) begin
              r_hit <= 1'b1;
            end
          end
          default: r_state <= StManual;
        endcase
      end
    end
  end

  assign capture_en    = (r_state == StCapture);
  assign tracking_mode = (r_state == StTrack);
  assign max_ready     = r_max_ready;
  assign c_x           = r_c_x;
  assign c_y           = r_c_y;
  assign lost          = r_lost;
  assign state         = r_state;

endmodule

// File: doc/track_ctrl.md
TRACK_CTRL -- requirements
Module: track_ctrl

Interface
REQ-001 Parameters SHALL be, one per line:
- VGA_WIDTH, 640, active pixels per line
- VGA_HEIGHT, 480, active lines per frame
- TEMPLATE_WIDTH, 32, template edge in pixels (even)
- MAX_STEP, 16, max centre movement per accepted candidate, per axis
- LOST_FRAMES, 8, consecutive frames without an accepted candidate before tracking is abandoned
REQ-002 Ports SHALL be, one per line:
- clk  in  1  single system clock; all logic on posedge
- rst_n  in  1  reset, asynchronous, active-low
- frame_start  in  1  one-cycle pulse at first pixel of each frame
- track_req  in  1  one-cycle pulse, operator requests tracking
- cancel  in  1  one-cycle pulse, return to manual positioning
- manual_x, manual_y  in  10 each  manually steered box centre
- cand_valid  in  1  one-cycle pulse, matcher result available
- cand_x, cand_y  in  10 each  matcher best-match centre
- cand_score  in  16  match score, higher is better
- score_thresh  in  16  minimum score for acceptance
- capture_en  out  1  template capture window active
- tracking_mode  out  1  high in TRACK state
- max_ready  out  1  one-cycle pulse, c_x/c_y updated from a candidate
- c_x, c_y  out  10 each  registered box centre
- lost  out  1  sticky target-lost flag
- state  out  2  current FSM state encoding
REQ-003 One clock; reset is asynchronous and active-low, port rst_n; clock port clk.

Function
REQ-004 FSM states SHALL be MANUAL=0, ARM=1, CAPTURE=2, TRACK=3; state output SHALL equal the encoding.
REQ-005 cancel SHALL move any state to MANUAL on the next edge, with priority over every other input; cancel in MANUAL has no effect.
REQ-006 MANUAL: track_req -> ARM and clears lost; c_x/c_y load clamp(manual_x), clamp(manual_y) every cycle.
REQ-007 ARM: c_x/c_y hold; frame_start -> CAPTURE; track_req ignored.
REQ-008 CAPTURE: capture_en=1 for every cycle in CAPTURE, 0 otherwise; c_x/c_y hold; next frame_start -> TRACK (capture lasts exactly one frame).
REQ-009 TRACK: tracking_mode=1; cand_valid with cand_score >= score_thresh (unsigned) accepts the candidate; lower scores are discarded.
REQ-010 Acceptance: per axis, signed 11-bit d = cand - c; d clamped to [-MAX_STEP, +MAX_STEP]; new = c + d, then clamped; registered on the same edge; max_ready pulses high the following cycle for exactly one cycle.
REQ-011 clamp(): x range [TEMPLATE_WIDTH/2, VGA_WIDTH-1-TEMPLATE_WIDTH/2] = [16,623]; y range [16,463] at defaults; no wrap-around on any input value including 1023.
REQ-012 Frame-hit flag set on acceptance; at each frame_start in TRACK: hit=1 -> miss_count=0; hit=0 -> miss_count+1; hit then cleared.
REQ-013 miss_count reaching LOST_FRAMES SHALL force MANUAL and set lost=1 on the same edge; lost holds until next accepted track_req or reset.
REQ-014 cand_valid and frame_start on the same cycle in TRACK: candidate SHALL be credited to the frame being closed.
REQ-015 miss_count and hit SHALL clear on entry to TRACK.
REQ-016 cand_valid outside TRACK SHALL be ignored (no max_ready, no centre change).

Reset
REQ-017 rst_n low SHALL immediately force state=MANUAL, c_x=320, c_y=240, capture_en=0, tracking_mode=0, max_ready=0, lost=0, miss_count=0, hit=0, including mid-CAPTURE or mid-TRACK.
REQ-018 After deassertion, first edge behaves as MANUAL (c_x/c_y load clamped manual inputs).

Verification
REQ-019 manual_x=5, manual_y=470 in MANUAL -> c_x=16, c_y=463 one cycle later.
REQ-020 track_req, then two frame_start pulses -> ARM, CAPTURE (capture_en high for exactly one frame), TRACK, tracking_mode=1.
REQ-021 TRACK at c=(320,240), cand=(400,230), score>=thresh -> c=(336,230), max_ready single pulse one cycle later; score<thresh -> no change, no pulse.
REQ-022 TRACK with no accepted candidate for 8 frame_starts -> state=MANUAL, lost=1 on 8th; next track_req clears lost.
REQ-023 cancel coincident with accepted cand_valid in TRACK -> MANUAL, no max_ready, c follows manual.
REQ-024 rst_n asserted mid-CAPTURE -> all outputs at reset values asynchronously, before next clk edge.
